rpn_eval: RTL and testbench
===========================

// Module: rpn_eval
// PURPOSE
//   Reverse-Polish evaluator sitting directly upstream of a stack instance and driving its
//   push/pop/data_in ports while consuming its data_out. Accepts a stream of tokens (operands or
//   operators) over a valid/ready handshake, performs stack arithmetic and emits results.
//   Tracks occupancy itself; never lets the attached stack over- or underflow.
// PARAMETERS
//   WIDTH  18  data width of tokens, stack entries and results
//   SIZE   4   log2 of the attached stack depth (depth = 2**SIZE entries)
// PORTS
//   clk        in   1        clock, all state updates on rising edge
//   reset      in   1        asynchronous, active-high; same net must reset the attached stack
//   tok_valid  in   1        token present
//   tok_ready  out  1        block can accept a token this cycle
//   tok_op     in   1        1 = operator token, 0 = operand token
//   tok_data   in   WIDTH    operand value; for operators opcode is tok_data[1:0]
//   stk_push   out  1        push strobe to stack
//   stk_pop    out  1        pop strobe to stack
//   stk_din    out  WIDTH    value to push
//   stk_dout   in   WIDTH    stack top entry; valid in any cycle following a push/pop edge
//   res_valid  out  1        one-cycle pulse: res_data valid
//   res_data   out  WIDTH    result value
//   err        out  1        sticky error flag (overflow/underflow), cleared only by reset
//   depth      out  SIZE+1   current number of stack entries, 0..2**SIZE
// BEHAVIOUR
// - Reset (async): state=IDLE, depth=0, err=0, res_valid=0, res_data=0, a/b regs=0; reset
//   mid-operation abandons the op, no res_valid emitted.
// - States: IDLE, POP_B, POP_A, EXEC. tok_ready = (state==IDLE); no tokens taken elsewhere.
// - Accept = tok_valid & tok_ready. stk_push/stk_pop/stk_din combinational from state + accept;
//   never both push and pop in one cycle.
// - Operand accepted in IDLE: if depth<2**SIZE -> stk_push=1, stk_din=tok_data same cycle,
//   depth+1. If depth==2**SIZE -> token consumed, no push, err<=1.
// - Opcodes: 00 ADD a+b, 01 SUB a-b, 10 XOR a^b, 11 PEEK. b = top, a = entry below top.
// - Binary op accepted (cycle T), depth>=2: T+1 POP_B: b<=stk_dout, stk_pop=1;
//   T+2 POP_A: a<=stk_dout, stk_pop=1; T+3 EXEC: stk_push=1, stk_din=result, depth-1 net;
//   T+4 res_valid=1, res_data=result, state IDLE (tok_ready=1 at T+4).
// - Binary op with depth<2: token consumed, no stack activity, err<=1, stays IDLE.
// - PEEK accepted at T with depth>=1: no stack activity; T+1 res_valid=1, res_data=stk_dout
//   sampled at T. PEEK with depth==0: consumed, err<=1, no res_valid.
// - Arithmetic modulo 2**WIDTH: carries/borrows discarded, results wrap.
// - depth updates on the push/pop edges; depth never exceeds 2**SIZE nor goes below 0.
// - res_valid is a single-cycle pulse; there is no result backpressure.
// TESTING
// 1 Reset asserted -> tok_ready=1, depth=0, err=0, res_valid=0, stk_push=stk_pop=0 at once.
// 2 Push 5, push 3, SUB -> stk_pop at T+1,T+2, stk_push din=2 at T+3, res_valid res_data=2 at
//   T+4, depth=1.
// 3 Wrap: push 0, push 1, SUB -> res_data=18'h3FFFF; push 1, ADD -> res_data=0, depth=1.
// 4 Underflow: push 7, ADD -> err=1, no stk_pop, depth=1; PEEK -> res_data=7, depth=1.
// 5 Overflow (SIZE=2): push 5 operands -> only 4 stk_push pulses, depth=4, err=1 after 5th.
// 6 Reset pulse while in POP_A -> IDLE, depth=0, no res_valid; next push/ADD sequence correct.

Source files
------------

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator driving an external stack's push/pop/data_in and reading its top entry.
// Tracks stack occupancy locally so the attached stack is never over- or underflowed.
module rpn_eval #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [SIZE:0]    depth
);

  typedef enum logic [1:0] {IDLE, POP_B, POP_A, EXEC} state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [SIZE:0] FULL = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0] ONE  = {{SIZE{1'b0}}, 1'b1};
  localparam logic [SIZE:0] TWO  = ONE + ONE;

  state_t           state_q, state_d;
  logic [SIZE:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result;
  logic             accept;

  assign tok_ready = (state_q == IDLE);
  assign accept    = tok_valid & tok_ready;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;
  assign depth     = depth_q;

  always_comb begin
    result = '0;
    unique case (op_q)
      OP_ADD:  result = a_q + b_q;
      OP_SUB:  result = a_q - b_q;
      OP_XOR:  result = a_q ^ b_q;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_din     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!tok_op) begin
            if (depth_q != FULL) begin
              stk_push = 1'b1;
              stk_din  = tok_data;
              depth_d  = depth_q + ONE;
            end else begin
              err_d = 1'b1;
            end
          end else if (tok_data[1:0] == OP_PEEK) begin
            // Top entry is already on stk_dout; no stack traffic needed.
            if (depth_q != '0) begin
              res_valid_d = 1'b1;
              res_data_d  = stk_dout;
            end else begin
              err_d = 1'b1;
            end
          end else if (depth_q >= TWO) begin
            op_d    = tok_data[1:0];
            state_d = POP_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      POP_B: begin
        stk_pop = 1'b1;
        b_d     = stk_dout;
        depth_d = depth_q - ONE;
        state_d = POP_A;
      end
      POP_A: begin
        stk_pop = 1'b1;
        a_d     = stk_dout;
        depth_d = depth_q - ONE;
        state_d = EXEC;
      end
      EXEC: begin
        stk_push    = 1'b1;
        stk_din     = result;
        depth_d     = depth_q + ONE;
        res_valid_d = 1'b1;
        res_data_d  = result;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
    end
  end

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval (SIZE=2) with a behavioural 4-entry stack attached to its stack ports.
module tb_rpn_eval;

  localparam int W = 18;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_op = 1'b0;
  logic [W-1:0]  tok_data = '0;
  logic          stk_push, stk_pop;
  logic [W-1:0]  stk_din, stk_dout;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          err;
  logic [S:0]    depth;

  rpn_eval #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_data(tok_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout), .res_valid(res_valid), .res_data(res_data),
    .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  // Behavioural stack sharing the reset net
  logic [W-1:0] mem [0:3];
  int           sp;
  always @(posedge clk or posedge reset) begin
    if (reset) sp <= 0;
    else if (stk_push && sp < 4) begin mem[sp] <= stk_din; sp <= sp + 1; end
    else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  always_comb stk_dout = (sp > 0) ? mem[sp-1] : '0;

  int push_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (stk_push) push_cnt++;
    if (stk_push && stk_pop) both_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    tok_valid = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present one token, then watch six cycles for a result pulse.
  task automatic send_tok(input logic op, input logic [W-1:0] data,
                          output logic got, output logic [W-1:0] rd);
    for (int i = 0; i < 10 && !tok_ready; i++) begin @(posedge clk); #1; end
    chk("tok_ready_before_send", tok_ready, 1);
    tok_op = op; tok_data = data; tok_valid = 1'b1;
    @(posedge clk); #1;
    tok_valid = 1'b0;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid && !got) begin got = 1'b1; rd = res_data; end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit           rst;
    bit           op;
    logic [W-1:0] data;
    bit           exp_rv;
    logic [W-1:0] exp_rd;
    logic [S:0]   exp_depth;
    bit           exp_err;
  } vec_t;

  vec_t vecs [18];
  logic         got;
  logic [W-1:0] rd;
  int           base;
  int           rv_seen;

  initial begin
    vecs[0]  = '{1, 0, 18'd5,      0, 18'd0,      3'd1, 0};
    vecs[1]  = '{0, 0, 18'd3,      0, 18'd0,      3'd2, 0};
    vecs[2]  = '{0, 1, 18'd1,      1, 18'd2,      3'd1, 0};
    vecs[3]  = '{1, 0, 18'd0,      0, 18'd0,      3'd1, 0};
    vecs[4]  = '{0, 0, 18'd1,      0, 18'd0,      3'd2, 0};
    vecs[5]  = '{0, 1, 18'd1,      1, 18'h3FFFF,  3'd1, 0};
    vecs[6]  = '{0, 0, 18'd1,      0, 18'd0,      3'd2, 0};
    vecs[7]  = '{0, 1, 18'd0,      1, 18'd0,      3'd1, 0};
    vecs[8]  = '{0, 0, 18'h15555,  0, 18'd0,      3'd2, 0};
    vecs[9]  = '{0, 1, 18'd2,      1, 18'h15555,  3'd1, 0};
    vecs[10] = '{0, 0, 18'h3FFFF,  0, 18'd0,      3'd2, 0};
    vecs[11] = '{0, 1, 18'd2,      1, 18'h2AAAA,  3'd1, 0};
    vecs[12] = '{0, 1, 18'd3,      1, 18'h2AAAA,  3'd1, 0};
    vecs[13] = '{1, 0, 18'd7,      0, 18'd0,      3'd1, 0};
    vecs[14] = '{0, 1, 18'd0,      0, 18'd0,      3'd1, 1};
    vecs[15] = '{0, 1, 18'd3,      1, 18'd7,      3'd1, 1};
    vecs[16] = '{1, 1, 18'd3,      0, 18'd0,      3'd0, 1};
    vecs[17] = '{1, 1, 18'd1,      0, 18'd0,      3'd0, 1};

    // Reset state is visible while reset is still asserted
    #1;
    chk("rst_tok_ready", tok_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_err", err, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_res_data", res_data, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      send_tok(vecs[i].op, vecs[i].data, got, rd);
      chk($sformatf("v%0d_res_valid", i), got, vecs[i].exp_rv);
      if (vecs[i].exp_rv) chk($sformatf("v%0d_res_data", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_depth", i), depth, vecs[i].exp_depth);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
    end

    // Cycle-accurate SUB: 5 - 3
    do_reset();
    send_tok(1'b0, 18'd5, got, rd);
    send_tok(1'b0, 18'd3, got, rd);
    tok_op = 1'b1; tok_data = 18'd1; tok_valid = 1'b1;
    @(negedge clk);
    chk("sub_T_pop", stk_pop, 0);
    chk("sub_T_push", stk_push, 0);
    @(posedge clk); #1; tok_valid = 1'b0;
    @(negedge clk);
    chk("sub_T1_pop", stk_pop, 1);
    chk("sub_T1_ready", tok_ready, 0);
    @(negedge clk);
    chk("sub_T2_pop", stk_pop, 1);
    chk("sub_T2_res_valid", res_valid, 0);
    @(negedge clk);
    chk("sub_T3_push", stk_push, 1);
    chk("sub_T3_pop", stk_pop, 0);
    chk("sub_T3_din", stk_din, 2);
    @(negedge clk);
    chk("sub_T4_res_valid", res_valid, 1);
    chk("sub_T4_res_data", res_data, 2);
    chk("sub_T4_ready", tok_ready, 1);
    chk("sub_T4_depth", depth, 1);
    @(negedge clk);
    chk("sub_T5_res_valid", res_valid, 0);
    @(posedge clk); #1;

    // Overflow: five operands into a four-entry stack
    do_reset();
    base = push_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_tok(1'b0, W'(i), got, rd);
      chk("ovf_err_before", err, 0);
    end
    send_tok(1'b0, 18'd5, got, rd);
    chk("ovf_push_count", push_cnt - base, 4);
    chk("ovf_depth", depth, 4);
    chk("ovf_err", err, 1);
    send_tok(1'b1, 18'd3, got, rd);
    chk("ovf_peek_valid", got, 1);
    chk("ovf_peek_data", rd, 4);
    send_tok(1'b1, 18'd1, got, rd);
    chk("full_sub_data", rd, 18'h3FFFF);
    chk("full_sub_depth", depth, 3);

    // Reset while in POP_A
    do_reset();
    send_tok(1'b0, 18'd5, got, rd);
    send_tok(1'b0, 18'd3, got, rd);
    tok_op = 1'b1; tok_data = 18'd0; tok_valid = 1'b1;
    @(posedge clk); #1; tok_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_popa", stk_pop, 1);
    reset = 1'b1;
    #1;
    chk("midrst_ready", tok_ready, 1);
    chk("midrst_depth", depth, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_pop", stk_pop, 0);
    #2 reset = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    chk("midrst_no_result", rv_seen, 0);
    @(posedge clk); #1;
    send_tok(1'b0, 18'd2, got, rd);
    send_tok(1'b0, 18'd4, got, rd);
    send_tok(1'b1, 18'd0, got, rd);
    chk("midrst_add_valid", got, 1);
    chk("midrst_add_data", rd, 6);
    chk("midrst_add_depth", depth, 1);
    chk("midrst_add_err", err, 0);

    chk("push_pop_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
